// File: rtl/conv_job_scheduler.sv
// ---------------------------------------------------------------------------
// conv_job_scheduler
//
// Walks one convolution engine across a full input feature map (stride 1, no
// padding). For every output pixel it issues the window's top-left address
// with a start pulse, waits for the engine to finish, and then pushes the
// result into the OFM SRAM through a ready/valid write port. It also owns
// job progress, abort handling and a per-pixel watchdog.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), async active-high reset
//   i_job_start         start request, honoured only while idle
//   i_abort             synchronous abort, honoured in any busy state
//   i_ifm_base          IFM base address, latched on an accepted start
//   i_ofm_base          OFM base address, latched on an accepted start
//   o_busy              high in every state except idle
//   o_job_done          one-cycle pulse on normal completion
//   o_error             one-cycle pulse when the watchdog fires
//   o_conv_start        one-cycle start pulse to the engine
//   o_win_base          window top-left address, valid with o_conv_start
//   i_conv_done         engine completion pulse
//   i_conv_result       engine result, valid with i_conv_done
//   o_ofm_we            OFM write valid
//   o_ofm_addr          OFM write address (ofm_base + pixel index)
//   o_ofm_wdata         OFM write data
//   i_ofm_ready         OFM write accepted when o_ofm_we && i_ofm_ready
//   o_pix_count         pixels written in the current or last job
// ---------------------------------------------------------------------------
module conv_job_scheduler #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_job_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_ifm_base,
  input  logic [ADDR_WIDTH-1:0] i_ofm_base,
  output logic                  o_busy,
  output logic                  o_job_done,
  output logic                  o_error,
  output logic                  o_conv_start,
  output logic [ADDR_WIDTH-1:0] o_win_base,
  input  logic                  i_conv_done,
  input  logic [DATA_WIDTH-1:0] i_conv_result,
  output logic                  o_ofm_we,
  output logic [ADDR_WIDTH-1:0] o_ofm_addr,
  output logic [DATA_WIDTH-1:0] o_ofm_wdata,
  input  logic                  i_ofm_ready,
  output logic [ADDR_WIDTH-1:0] o_pix_count
);

  localparam int OUT_W = IMG_W - KERNEL_SIZE + 1;
  localparam int OUT_H = IMG_H - KERNEL_SIZE + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IMG_W_A  = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(OUT_W - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(OUT_H - 1);
  localparam logic [WD_W-1:0]       WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ifm_base_q;
  logic [ADDR_WIDTH-1:0] ofm_base_q;
  logic [ADDR_WIDTH-1:0] row;
  logic [ADDR_WIDTH-1:0] col;
  logic [WD_W-1:0]       wdog;

  logic                  col_last;
  logic                  pix_last;
  logic [ADDR_WIDTH-1:0] next_row;
  logic [ADDR_WIDTH-1:0] next_col;
  logic [ADDR_WIDTH-1:0] next_win;

  // Position of the pixel that follows the one being written, and the window
  // address it needs. Computed ahead so o_win_base can be registered on the
  // same edge that moves WRITE back to ISSUE. Arithmetic wraps at ADDR_WIDTH.
  always_comb begin
    col_last = (col == COL_LAST);
    pix_last = col_last && (row == ROW_LAST);
    next_col = col_last ? '0 : col + ONE_A;
    next_row = col_last ? row + ONE_A : row;
    next_win = ifm_base_q + next_row * IMG_W_A + next_col;
  end

  // Job sequencer. Every output is registered: the value an output should
  // carry in a state is loaded on the edge that enters that state, and the
  // pulse outputs default back to zero every cycle. Abort is checked ahead of
  // the per-state logic so it beats a coincident done or write accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      ifm_base_q   <= '0;
      ofm_base_q   <= '0;
      row          <= '0;
      col          <= '0;
      wdog         <= '0;
      o_busy       <= 1'b0;
      o_job_done   <= 1'b0;
      o_error      <= 1'b0;
      o_conv_start <= 1'b0;
      o_win_base   <= '0;
      o_ofm_we     <= 1'b0;
      o_ofm_addr   <= '0;
      o_ofm_wdata  <= '0;
      o_pix_count  <= '0;
    end else begin
      o_conv_start <= 1'b0;
      o_job_done   <= 1'b0;
      o_error      <= 1'b0;
      if (state != S_IDLE && i_abort) begin
        state    <= S_IDLE;
        o_busy   <= 1'b0;
        o_ofm_we <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_job_start) begin
              ifm_base_q   <= i_ifm_base;
              ofm_base_q   <= i_ofm_base;
              row          <= '0;
              col          <= '0;
              o_pix_count  <= '0;
              o_conv_start <= 1'b1;
              o_win_base   <= i_ifm_base;
              o_busy       <= 1'b1;
              state        <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            wdog  <= '0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (i_conv_done) begin
              o_ofm_wdata <= i_conv_result;
              o_ofm_addr  <= ofm_base_q + o_pix_count;
              o_ofm_we    <= 1'b1;
              state       <= S_WRITE;
            end else if (wdog == WD_LAST) begin
              // This is the TIMEOUT-th consecutive WAIT cycle without done.
              o_error <= 1'b1;
              o_busy  <= 1'b0;
              state   <= S_IDLE;
            end else begin
              wdog <= wdog + WD_ONE;
            end
          end
          S_WRITE: begin
            if (i_ofm_ready) begin
              o_ofm_we    <= 1'b0;
              o_pix_count <= o_pix_count + ONE_A;
              row         <= next_row;
              col         <= next_col;
              if (pix_last) begin
                o_job_done <= 1'b1;
                state      <= S_DONE;
              end else begin
                o_conv_start <= 1'b1;
                o_win_base   <= next_win;
                state        <= S_ISSUE;
              end
            end
          end
          S_DONE: begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
          default: begin
            o_busy   <= 1'b0;
            o_ofm_we <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_conv_job_scheduler
//
// Directed bench for conv_job_scheduler (defaults, TIMEOUT overridden to 16).
// A behavioural engine/OFM-sink driver runs one job and records every start
// address, every accepted write, and the done/error pulses; each test task
// then compares those records against hand-derived expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_job_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_job_start;
  logic       i_abort;
  logic [7:0] i_ifm_base;
  logic [7:0] i_ofm_base;
  logic       i_conv_done;
  logic [7:0] i_conv_result;
  logic       i_ofm_ready;
  logic       o_busy;
  logic       o_job_done;
  logic       o_error;
  logic       o_conv_start;
  logic [7:0] o_win_base;
  logic       o_ofm_we;
  logic [7:0] o_ofm_addr;
  logic [7:0] o_ofm_wdata;
  logic [7:0] o_pix_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] st_win[$];
  logic [7:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int n_starts;
  int n_done;
  int n_err;
  int err_cyc;
  int last_start_cyc;
  bit timed_out;
  bit busy_at_err;
  bit stall_stable;
  bit start_in_stall;

  always #5 i_clk = ~i_clk;

  conv_job_scheduler #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .IMG_W      (8),
    .IMG_H      (8),
    .KERNEL_SIZE(3),
    .TIMEOUT    (16)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_job_start  (i_job_start),
    .i_abort      (i_abort),
    .i_ifm_base   (i_ifm_base),
    .i_ofm_base   (i_ofm_base),
    .o_busy       (o_busy),
    .o_job_done   (o_job_done),
    .o_error      (o_error),
    .o_conv_start (o_conv_start),
    .o_win_base   (o_win_base),
    .i_conv_done  (i_conv_done),
    .i_conv_result(i_conv_result),
    .o_ofm_we     (o_ofm_we),
    .o_ofm_addr   (o_ofm_addr),
    .o_ofm_wdata  (o_ofm_wdata),
    .i_ofm_ready  (i_ofm_ready),
    .o_pix_count  (o_pix_count)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Expected window address for output pixel k of a 6x6 OFM over an 8-wide IFM.
  function automatic logic [7:0] exp_win(input logic [7:0] base, input int k);
    return 8'(int'(base) + (k / 6) * 8 + (k % 6));
  endfunction

  // Expected engine result the driver returns for pixel k.
  function automatic logic [7:0] exp_data(input int k);
    return 8'(k * 7 + 3);
  endfunction

  // Runs one job: engine answers done_dly cycles after each start (never if
  // negative), the sink stalls pixel stall_pix for 3 cycles, abort is raised
  // in the first WAIT cycle of pixel abort_pix, and noise injects a mid-job
  // start plus spurious done pulses during ISSUE.
  task automatic run_job(input logic [7:0] ifm, input logic [7:0] ofm, input int done_dly,
                         input int stall_pix, input int abort_pix, input bit noise, input int max_cyc);
    int cyc;
    int done_cnt;
    int stall_left;
    bit stall_active;
    logic [7:0] hold_addr;
    logic [7:0] hold_data;
    st_win.delete(); wr_addr.delete(); wr_data.delete();
    n_starts = 0; n_done = 0; n_err = 0; err_cyc = -1; last_start_cyc = -1;
    timed_out = 0; busy_at_err = 1; stall_stable = 1; start_in_stall = 0;
    cyc = 0; done_cnt = -1; stall_left = 3; stall_active = 0;
    hold_addr = '0; hold_data = '0;
    i_ifm_base = ifm; i_ofm_base = ofm; i_job_start = 1'b1;
    tick();
    i_ifm_base = 8'h55; i_ofm_base = 8'h55;
    while (1) begin
      i_conv_done = 1'b0; i_abort = 1'b0; i_ofm_ready = 1'b0; i_job_start = 1'b0;
      if (o_job_done) n_done++;
      if (o_error) begin
        n_err++; err_cyc = cyc; busy_at_err = o_busy;
      end
      if (!o_busy) break;
      if (cyc >= max_cyc) begin
        timed_out = 1;
        break;
      end
      if (o_conv_start) begin
        st_win.push_back(o_win_base);
        n_starts++;
        last_start_cyc = cyc;
        if (stall_active) start_in_stall = 1;
        done_cnt = done_dly;
        if (noise) begin
          i_conv_done = 1'b1; i_conv_result = 8'hEE;
        end
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (abort_pix >= 0 && n_starts == abort_pix + 1) begin
          i_abort = 1'b1; done_cnt = -1;
        end else if (done_cnt == 0) begin
          i_conv_done = 1'b1; i_conv_result = exp_data(n_starts - 1);
        end
      end
      if (o_ofm_we) begin
        if (wr_addr.size() == stall_pix && stall_left > 0) begin
          if (stall_left == 3) begin
            hold_addr = o_ofm_addr; hold_data = o_ofm_wdata; stall_active = 1;
          end else if (o_ofm_addr !== hold_addr || o_ofm_wdata !== hold_data) begin
            stall_stable = 0;
          end
          stall_left--;
        end else begin
          if (stall_active && (o_ofm_addr !== hold_addr || o_ofm_wdata !== hold_data)) stall_stable = 0;
          stall_active = 0;
          i_ofm_ready = 1'b1;
          wr_addr.push_back(o_ofm_addr);
          wr_data.push_back(o_ofm_wdata);
        end
      end else if (stall_active) begin
        stall_stable = 0;
      end
      if (noise && n_starts == 3) begin
        i_job_start = 1'b1; i_ifm_base = 8'h00; i_ofm_base = 8'h00;
      end
      cyc++;
      tick();
    end
    i_conv_done = 1'b0; i_abort = 1'b0; i_ofm_ready = 1'b0; i_job_start = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) tick();
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", o_busy); end
    total++; if (o_job_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_job_done: got %b want 0", o_job_done); end
    total++; if (o_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_error: got %b want 0", o_error); end
    total++; if (o_conv_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_conv_start: got %b want 0", o_conv_start); end
    total++; if (o_win_base !== 8'h00) begin bad++; $display("[TB] FAIL reset_win_base: got %h want 00", o_win_base); end
    total++; if (o_ofm_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_ofm_we: got %b want 0", o_ofm_we); end
    total++; if ({o_ofm_addr, o_ofm_wdata} !== 16'h0000) begin bad++; $display("[TB] FAIL reset_ofm_bus: got %h want 0000", {o_ofm_addr, o_ofm_wdata}); end
    total++; if (o_pix_count !== 8'h00) begin bad++; $display("[TB] FAIL reset_pix_count: got %h want 00", o_pix_count); end
    #2 i_rst = 1'b0;
    tick();
  endtask

  task automatic test_full_job();
    run_job(8'h10, 8'h80, 2, -1, -1, 0, 400);
    total++; if (timed_out) begin bad++; $display("[TB] FAIL full_timeout: got busy after 400 cycles want idle"); end
    total++; if (n_starts != 36) begin bad++; $display("[TB] FAIL full_starts: got %0d want 36", n_starts); end
    total++; if (wr_addr.size() != 36) begin bad++; $display("[TB] FAIL full_writes: got %0d want 36", wr_addr.size()); end
    for (int k = 0; k < 36 && k < st_win.size(); k++) begin
      total++;
      if (st_win[k] !== exp_win(8'h10, k)) begin bad++; $display("[TB] FAIL full_win[%0d]: got %h want %h", k, st_win[k], exp_win(8'h10, k)); end
    end
    for (int k = 0; k < 36 && k < wr_addr.size(); k++) begin
      total++;
      if (wr_addr[k] !== 8'(8'h80 + k) || wr_data[k] !== exp_data(k)) begin
        bad++; $display("[TB] FAIL full_write[%0d]: got %h/%h want %h/%h", k, wr_addr[k], wr_data[k], 8'(8'h80 + k), exp_data(k));
      end
    end
    total++; if (st_win.size() == 36 && st_win[35] !== 8'h3D) begin bad++; $display("[TB] FAIL full_last_win: got %h want 3d", st_win[35]); end
    total++; if (n_done != 1) begin bad++; $display("[TB] FAIL full_job_done: got %0d pulses want 1", n_done); end
    total++; if (n_err != 0) begin bad++; $display("[TB] FAIL full_error: got %0d pulses want 0", n_err); end
    total++; if (o_pix_count !== 8'd36) begin bad++; $display("[TB] FAIL full_pix_count: got %0d want 36", o_pix_count); end
    tick();
    total++; if (o_job_done !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("[TB] FAIL full_idle_after: got done=%b busy=%b want 0/0", o_job_done, o_busy); end
  endtask

  task automatic test_stall();
    run_job(8'h10, 8'h80, 2, 5, -1, 0, 400);
    total++; if (!stall_stable) begin bad++; $display("[TB] FAIL stall_stable: got changing we/addr/data want held"); end
    total++; if (start_in_stall) begin bad++; $display("[TB] FAIL stall_no_start: got conv_start during stall want none"); end
    total++; if (wr_addr.size() > 5 && wr_addr[5] !== 8'h85) begin bad++; $display("[TB] FAIL stall_addr: got %h want 85", wr_addr[5]); end
    total++; if (n_starts != 36 || wr_addr.size() != 36) begin bad++; $display("[TB] FAIL stall_counts: got %0d starts %0d writes want 36/36", n_starts, wr_addr.size()); end
    for (int k = 0; k < 36 && k < wr_addr.size(); k++) begin
      total++;
      if (wr_addr[k] !== 8'(8'h80 + k)) begin bad++; $display("[TB] FAIL stall_seq[%0d]: got %h want %h", k, wr_addr[k], 8'(8'h80 + k)); end
    end
    total++; if (n_done != 1 || o_pix_count !== 8'd36) begin bad++; $display("[TB] FAIL stall_done: got %0d pulses pix=%0d want 1/36", n_done, o_pix_count); end
  endtask

  task automatic test_watchdog();
    run_job(8'h10, 8'h80, -1, -1, -1, 0, 100);
    total++; if (n_err != 1) begin bad++; $display("[TB] FAIL wd_error_count: got %0d want 1", n_err); end
    total++; if (err_cyc - last_start_cyc != 17) begin bad++; $display("[TB] FAIL wd_latency: got %0d want 17", err_cyc - last_start_cyc); end
    total++; if (busy_at_err !== 1'b0) begin bad++; $display("[TB] FAIL wd_busy: got %b want 0", busy_at_err); end
    total++; if (wr_addr.size() != 0 || n_done != 0) begin bad++; $display("[TB] FAIL wd_side_effects: got %0d writes %0d done want 0/0", wr_addr.size(), n_done); end
    total++; if (n_starts != 1) begin bad++; $display("[TB] FAIL wd_starts: got %0d want 1", n_starts); end
    tick();
    total++; if (o_error !== 1'b0) begin bad++; $display("[TB] FAIL wd_pulse_width: got %b want 0", o_error); end
  endtask

  task automatic test_abort();
    run_job(8'h10, 8'h80, 2, -1, 10, 0, 200);
    total++; if (n_starts != 11) begin bad++; $display("[TB] FAIL abort_starts: got %0d want 11", n_starts); end
    total++; if (o_pix_count !== 8'd10 || wr_addr.size() != 10) begin bad++; $display("[TB] FAIL abort_pix_count: got %0d (%0d writes) want 10", o_pix_count, wr_addr.size()); end
    total++; if (n_done != 0 || n_err != 0) begin bad++; $display("[TB] FAIL abort_pulses: got done=%0d err=%0d want 0/0", n_done, n_err); end
    total++; if (o_ofm_we !== 1'b0 || o_conv_start !== 1'b0) begin bad++; $display("[TB] FAIL abort_outputs: got we=%b start=%b want 0/0", o_ofm_we, o_conv_start); end
    run_job(8'h10, 8'h80, 2, -1, -1, 0, 400);
    total++; if (st_win.size() == 0 || st_win[0] !== 8'h10) begin bad++; $display("[TB] FAIL restart_win: got %h want 10", (st_win.size() > 0) ? st_win[0] : 8'hxx); end
    total++; if (wr_addr.size() == 0 || wr_addr[0] !== 8'h80) begin bad++; $display("[TB] FAIL restart_addr: got %h want 80", (wr_addr.size() > 0) ? wr_addr[0] : 8'hxx); end
    total++; if (n_done != 1 || o_pix_count !== 8'd36) begin bad++; $display("[TB] FAIL restart_done: got %0d pulses pix=%0d want 1/36", n_done, o_pix_count); end
  endtask

  task automatic test_wrap();
    run_job(8'hFE, 8'hF0, 2, -1, -1, 0, 400);
    total++; if (st_win.size() < 3 || st_win[0] !== 8'hFE || st_win[1] !== 8'hFF || st_win[2] !== 8'h00) begin
      bad++; $display("[TB] FAIL wrap_win_head: got first starts wrong want fe ff 00");
    end
    total++; if (wr_addr.size() < 17 || wr_addr[15] !== 8'hFF || wr_addr[16] !== 8'h00) begin
      bad++; $display("[TB] FAIL wrap_addr: got pixel 15/16 addr wrong want ff/00");
    end
    for (int k = 0; k < 36 && k < st_win.size(); k++) begin
      total++;
      if (st_win[k] !== exp_win(8'hFE, k)) begin bad++; $display("[TB] FAIL wrap_win[%0d]: got %h want %h", k, st_win[k], exp_win(8'hFE, k)); end
    end
    total++; if (n_done != 1 || wr_addr.size() != 36) begin bad++; $display("[TB] FAIL wrap_done: got %0d pulses %0d writes want 1/36", n_done, wr_addr.size()); end
  endtask

  task automatic test_ignored();
    i_conv_done = 1'b1; i_conv_result = 8'hEE;
    tick();
    i_conv_done = 1'b0;
    tick();
    total++; if (o_busy !== 1'b0 || o_ofm_we !== 1'b0 || o_conv_start !== 1'b0) begin
      bad++; $display("[TB] FAIL idle_done_ignored: got busy=%b we=%b start=%b want 0/0/0", o_busy, o_ofm_we, o_conv_start);
    end
    run_job(8'h10, 8'h80, 2, -1, -1, 1, 400);
    total++; if (n_starts != 36 || wr_addr.size() != 36) begin bad++; $display("[TB] FAIL noise_counts: got %0d starts %0d writes want 36/36", n_starts, wr_addr.size()); end
    for (int k = 0; k < 36 && k < wr_addr.size(); k++) begin
      total++;
      if (st_win[k] !== exp_win(8'h10, k) || wr_addr[k] !== 8'(8'h80 + k) || wr_data[k] !== exp_data(k)) begin
        bad++; $display("[TB] FAIL noise_pixel[%0d]: got %h/%h/%h want %h/%h/%h", k, st_win[k], wr_addr[k], wr_data[k], exp_win(8'h10, k), 8'(8'h80 + k), exp_data(k));
      end
    end
    total++; if (n_done != 1) begin bad++; $display("[TB] FAIL noise_done: got %0d want 1", n_done); end
  endtask

  task automatic test_reset_mid_write();
    i_ifm_base = 8'h10; i_ofm_base = 8'h80; i_job_start = 1'b1;
    tick();
    i_job_start = 1'b0;
    tick();
    i_conv_done = 1'b1; i_conv_result = 8'h77; i_ofm_ready = 1'b0;
    tick();
    i_conv_done = 1'b0;
    total++; if (o_ofm_we !== 1'b1 || o_ofm_wdata !== 8'h77) begin bad++; $display("[TB] FAIL rstw_in_write: got we=%b data=%h want 1/77", o_ofm_we, o_ofm_wdata); end
    #2 i_rst = 1'b1;
    #1;
    total++; if ({o_busy, o_job_done, o_error, o_conv_start, o_ofm_we} !== 5'b0) begin
      bad++; $display("[TB] FAIL rstw_flags: got %b want 00000", {o_busy, o_job_done, o_error, o_conv_start, o_ofm_we});
    end
    total++; if ({o_win_base, o_ofm_addr, o_ofm_wdata, o_pix_count} !== 32'h0) begin
      bad++; $display("[TB] FAIL rstw_buses: got %h want 00000000", {o_win_base, o_ofm_addr, o_ofm_wdata, o_pix_count});
    end
    #2 i_rst = 1'b0;
    i_ofm_ready = 1'b1;
    repeat (3) tick();
    total++; if (o_busy !== 1'b0 || o_job_done !== 1'b0 || o_error !== 1'b0) begin
      bad++; $display("[TB] FAIL rstw_after: got busy=%b done=%b err=%b want 0/0/0", o_busy, o_job_done, o_error);
    end
    i_ofm_ready = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_job_start = 1'b0; i_abort = 1'b0;
    i_ifm_base = '0; i_ofm_base = '0;
    i_conv_done = 1'b0; i_conv_result = '0; i_ofm_ready = 1'b0;
    test_reset();
    test_full_job();
    test_stall();
    test_watchdog();
    test_abort();
    test_wrap();
    test_ignored();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
